// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves ALU operands, detects hazards and inserts bubbles.
// Define MIPS_FORWARD_EN to enable EX/MEM forwarding; otherwise RAW hazards stall.

`ifndef ALU_OP_NOP
`define ALU_OP_NOP 4'h0
`endif

module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [3:0]  id_alu_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [15:0] id_imm,
  input  logic        id_use_imm,
  input  logic        id_imm_zext,
  input  logic        id_use_shamt,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic [31:0] fwd_ex_data,
  input  logic [4:0]  fwd_mem_rd,
  input  logic        fwd_mem_reg_write,
  input  logic [31:0] fwd_mem_data,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [31:0] stall_count
);

  logic        ex_valid_q, ex_valid_d;
  logic [3:0]  ex_alu_op_q, ex_alu_op_d;
  logic [31:0] ex_a_q, ex_a_d;
  logic [31:0] ex_b_q, ex_b_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic [31:0] stall_q, stall_d;

  logic        rs_used, rt_used;
  logic        rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic        hazard;
  logic [31:0] imm_ext, rs_res, rt_res;

  assign rs_used = ~id_use_shamt;
  assign rt_used = ~id_use_imm;

  // Register 0 is hardwired, so it never matches an in-flight writer.
  assign rs_ex_hit  = ex_valid_q & ex_reg_write_q & (ex_rd_q == id_rs) & (id_rs != 5'd0);
  assign rt_ex_hit  = ex_valid_q & ex_reg_write_q & (ex_rd_q == id_rt) & (id_rt != 5'd0);
  assign rs_mem_hit = fwd_mem_reg_write & (fwd_mem_rd == id_rs) & (id_rs != 5'd0);
  assign rt_mem_hit = fwd_mem_reg_write & (fwd_mem_rd == id_rt) & (id_rt != 5'd0);

`ifdef MIPS_FORWARD_EN
  // A load's data is not ready until MEM, so only an EX-stage load stalls.
  assign hazard = ex_mem_read_q & ((rs_used & rs_ex_hit) | (rt_used & rt_ex_hit));

  always_comb begin
    rs_res = id_rs_val;
    if (rs_ex_hit) begin
      rs_res = fwd_ex_data;
    end else if (rs_mem_hit) begin
      rs_res = fwd_mem_data;
    end
    rt_res = id_rt_val;
    if (rt_ex_hit) begin
      rt_res = fwd_ex_data;
    end else if (rt_mem_hit) begin
      rt_res = fwd_mem_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_data, fwd_mem_data};

  assign hazard = (rs_used & (rs_ex_hit | rs_mem_hit)) | (rt_used & (rt_ex_hit | rt_mem_hit));
  assign rs_res = id_rs_val;
  assign rt_res = id_rt_val;
`endif

  assign id_ready = ~hazard;
  assign imm_ext  = id_imm_zext ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};

  always_comb begin
    ex_valid_d     = 1'b0;
    ex_alu_op_d    = `ALU_OP_NOP;
    ex_a_d         = 32'h0;
    ex_b_d         = 32'h0;
    ex_rd_d        = 5'd0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    stall_d        = stall_q;
    if (!flush && id_valid && id_ready) begin
      ex_valid_d     = 1'b1;
      ex_alu_op_d    = id_alu_op;
      ex_a_d         = id_use_shamt ? {27'h0, id_shamt} : rs_res;
      ex_b_d         = id_use_imm ? imm_ext : rt_res;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write;
      ex_mem_read_d  = id_mem_read;
    end
    if (id_valid && !id_ready && !flush) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_alu_op_q    <= `ALU_OP_NOP;
      ex_a_q         <= 32'h0;
      ex_b_q         <= 32'h0;
      ex_rd_q        <= 5'd0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      stall_q        <= 32'h0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_a_q         <= ex_a_d;
      ex_b_q         <= ex_b_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      stall_q        <= stall_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_alu_op    = ex_alu_op_q;
  assign ex_a         = ex_a_q;
  assign ex_b         = ex_b_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: per-cycle model comparison plus directed literal checks.

`ifndef ALU_OP_NOP
`define ALU_OP_NOP 4'h0
`endif

module tb_id_ex_stage;

  localparam logic [3:0] NopOp = `ALU_OP_NOP;
`ifdef MIPS_FORWARD_EN
  localparam int unsigned FwdOn = 1;
`else
  localparam int unsigned FwdOn = 0;
`endif
  // Cumulative stall counts expected after each stalling section.
  localparam int unsigned StallA = FwdOn ? 0 : 2;
  localparam int unsigned StallB = StallA + (FwdOn ? 1 : 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_ready;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_val, id_rt_val;
  logic [15:0] id_imm;
  logic        id_use_imm, id_imm_zext, id_use_shamt, id_reg_write, id_mem_read;
  logic        flush;
  logic [31:0] fwd_ex_data, fwd_mem_data;
  logic [4:0]  fwd_mem_rd;
  logic        fwd_mem_reg_write;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, stall_count;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_imm_zext(id_imm_zext),
    .id_use_shamt(id_use_shamt), .id_shamt(id_shamt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_ex_data(fwd_ex_data), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_reg_write(fwd_mem_reg_write), .fwd_mem_data(fwd_mem_data),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: the instruction sitting in EX, as a plain record.
  typedef struct {
    bit          v;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bit          rw, mr;
  } ex_t;

  ex_t         m;
  int unsigned m_stalls;

  function automatic ex_t bubble();
    ex_t e;
    e.v = 0; e.op = NopOp; e.a = 0; e.b = 0; e.rd = 0; e.rw = 0; e.mr = 0;
    return e;
  endfunction

  function automatic bit in_ex(input logic [4:0] r);
    return m.v && m.rw && (m.rd == r) && (r != 0);
  endfunction

  function automatic bit in_mem(input logic [4:0] r);
    return fwd_mem_reg_write && (fwd_mem_rd == r) && (r != 0);
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    if (FwdOn != 0) return in_ex(r) && m.mr;
    return in_ex(r) || in_mem(r);
  endfunction

  function automatic bit m_ready();
    bit h;
    h = (!id_use_shamt && blocked(id_rs)) || (!id_use_imm && blocked(id_rt));
    return !h;
  endfunction

  function automatic logic [31:0] value_of(input logic [4:0] r, input logic [31:0] rf);
    if (FwdOn != 0 && in_ex(r)) return fwd_ex_data;
    if (FwdOn != 0 && in_mem(r)) return fwd_mem_data;
    return rf;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m        <= bubble();
      m_stalls <= 0;
    end else begin
      ex_t nx;
      bit  rdy;
      rdy = m_ready();
      nx  = bubble();
      if (!flush && id_valid && rdy) begin
        nx.v  = 1;
        nx.op = id_alu_op;
        nx.a  = id_use_shamt ? 32'(id_shamt) : value_of(id_rs, id_rs_val);
        if (id_use_imm)
          nx.b = id_imm_zext ? 32'(id_imm) : 32'(signed'(id_imm));
        else
          nx.b = value_of(id_rt, id_rt_val);
        nx.rd = id_rd;
        nx.rw = id_reg_write;
        nx.mr = id_mem_read;
      end
      if (id_valid && !rdy && !flush) m_stalls <= m_stalls + 1;
      m <= nx;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ex_valid", ex_valid, m.v);
      chk("m_ex_alu_op", ex_alu_op, m.op);
      chk("m_ex_a", ex_a, m.a);
      chk("m_ex_b", ex_b, m.b);
      chk("m_ex_rd", ex_rd, m.rd);
      chk("m_ex_reg_write", ex_reg_write, m.rw);
      chk("m_ex_mem_read", ex_mem_read, m.mr);
      chk("m_id_ready", id_ready, m_ready());
      chk("m_stall_count", stall_count, m_stalls);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_alu_op = 0; id_rs = 0; id_rt = 0; id_rs_val = 0; id_rt_val = 0;
    id_imm = 0; id_use_imm = 0; id_imm_zext = 0; id_use_shamt = 0; id_shamt = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    fwd_ex_data = 0; fwd_mem_rd = 0; fwd_mem_reg_write = 0; fwd_mem_data = 0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid = 1; id_alu_op = op; id_rs = rs; id_rt = rt; id_rs_val = rsv; id_rt_val = rtv;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_use_imm = 0; id_imm_zext = 0; id_use_shamt = 0; id_imm = 0; id_shamt = 0;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_alu_op", ex_alu_op, NopOp);
    chk("rst_ex_a", ex_a, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_ready", id_ready, 1);
    cmp_en = 1;
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // Immediate sign/zero extension
    instr(4'h2, 5'd1, 5'd0, 32'h10, 32'h0, 5'd2, 1, 0);
    id_imm = 16'hFFFC; id_use_imm = 1;
    cyc();
    chk("imm_valid", ex_valid, 1);
    chk("imm_sext_a", ex_a, 32'h0000_0010);
    chk("imm_sext_b", ex_b, 32'hFFFF_FFFC);
    instr(4'h3, 5'd4, 5'd0, 32'h10, 32'h0, 5'd8, 1, 0);
    id_imm = 16'hFFFC; id_use_imm = 1; id_imm_zext = 1;
    cyc();
    chk("imm_zext_b", ex_b, 32'h0000_FFFC);

    // Shift amount as A, rt as B
    instr(4'h4, 5'd0, 5'd9, 32'h0, 32'h1234, 5'd10, 1, 0);
    id_use_shamt = 1; id_shamt = 5'd7;
    cyc();
    chk("shamt_a", ex_a, 32'h7);
    chk("shamt_b", ex_b, 32'h1234);

    // Register 0 never forwards nor stalls
    instr(4'h1, 5'd0, 5'd0, 32'h55, 32'h66, 5'd0, 1, 0);
    fwd_ex_data = 32'h1234_5678; fwd_mem_rd = 5'd0; fwd_mem_reg_write = 1;
    fwd_mem_data = 32'hAAAA;
    cyc();
    chk("r0_a", ex_a, 32'h55);
    cyc();
    chk("r0_a_again", ex_a, 32'h55);
    chk("r0_b_again", ex_b, 32'h66);
    idle();

`ifdef MIPS_FORWARD_EN
    instr(4'h2, 5'd1, 5'd0, 32'h0, 32'h0, 5'd5, 1, 0);
    id_use_imm = 1;
    cyc();
    instr(4'h2, 5'd5, 5'd0, 32'h0, 32'h0, 5'd11, 1, 0);
    id_use_imm = 1;
    fwd_ex_data = 32'h1234_5678; fwd_mem_rd = 5'd5; fwd_mem_reg_write = 1;
    fwd_mem_data = 32'hAAAA;
    #1;
    chk("fwd_ready", id_ready, 1);
    cyc();
    chk("fwd_ex_prio", ex_a, 32'h1234_5678);
    cyc();
    chk("fwd_mem_only", ex_a, 32'hAAAA);
    idle();
`else
    instr(4'h2, 5'd7, 5'd0, 32'h77, 32'h0, 5'd12, 1, 0);
    id_use_imm = 1;
    fwd_mem_rd = 5'd7; fwd_mem_reg_write = 1; fwd_mem_data = 32'hDEAD;
    #1;
    chk("nofwd_ready0", id_ready, 0);
    cyc();
    chk("nofwd_bubble1", ex_valid, 0);
    cyc();
    chk("nofwd_bubble2", ex_valid, 0);
    chk("nofwd_stalls", stall_count, StallA);
    fwd_mem_reg_write = 0;
    #1;
    chk("nofwd_ready1", id_ready, 1);
    cyc();
    chk("nofwd_valid", ex_valid, 1);
    chk("nofwd_a", ex_a, 32'h77);
    idle();
`endif

    // Load-use
    instr(4'h2, 5'd1, 5'd0, 32'h0, 32'h0, 5'd3, 1, 1);
    id_use_imm = 1;
    cyc();
    instr(4'h2, 5'd3, 5'd0, 32'h33, 32'h0, 5'd13, 1, 0);
    id_use_imm = 1; fwd_ex_data = 32'h999;
    #1;
    chk("lu_ready0", id_ready, 0);
    cyc();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall", stall_count, StallA + 1);
    fwd_mem_rd = 5'd3; fwd_mem_reg_write = 1; fwd_mem_data = 32'hBEEF;
    #1;
`ifdef MIPS_FORWARD_EN
    chk("lu_ready1", id_ready, 1);
    cyc();
    chk("lu_fwd_mem", ex_a, 32'hBEEF);
    chk("lu_stall_total", stall_count, StallB);
`else
    chk("lu_ready_mem", id_ready, 0);
    cyc();
    chk("lu_bubble2", ex_valid, 0);
    fwd_mem_reg_write = 0;
    cyc();
    chk("lu_rf_a", ex_a, 32'h33);
    chk("lu_stall_total", stall_count, StallB);
`endif
    idle();

    // Flush beats a concurrent load-use hazard
    instr(4'h2, 5'd1, 5'd0, 32'h0, 32'h0, 5'd3, 1, 1);
    id_use_imm = 1;
    cyc();
    instr(4'h2, 5'd3, 5'd0, 32'h33, 32'h0, 5'd13, 1, 0);
    id_use_imm = 1; flush = 1;
    cyc();
    chk("flush_bubble", ex_valid, 0);
    chk("flush_stall", stall_count, StallB);
    idle();

    // rs == rt, both used
    instr(4'h2, 5'd1, 5'd0, 32'h0, 32'h0, 5'd6, 1, 0);
    id_use_imm = 1;
    cyc();
    instr(4'h6, 5'd6, 5'd6, 32'h66, 32'h66, 5'd14, 1, 0);
    fwd_ex_data = 32'h600D;
`ifdef MIPS_FORWARD_EN
    cyc();
    chk("same_a", ex_a, 32'h600D);
    chk("same_b", ex_b, 32'h600D);
`else
    cyc(); cyc();
    chk("same_a", ex_a, 32'h66);
    chk("same_b", ex_b, 32'h66);
`endif
    idle();

    // Asynchronous reset mid-stream
    instr(4'h5, 5'd2, 5'd0, 32'h1, 32'h0, 5'd15, 1, 1);
    id_use_imm = 1; id_imm = 16'h0042;
    cyc();
    rst_n = 0;
    #1;
    chk("mrst_ex_valid", ex_valid, 0);
    chk("mrst_ex_alu_op", ex_alu_op, NopOp);
    chk("mrst_ex_a", ex_a, 0);
    chk("mrst_ex_b", ex_b, 0);
    chk("mrst_stall", stall_count, 0);
    chk("mrst_ready", id_ready, 1);
    cyc();
    rst_n = 1;
    idle();
    cyc(); cyc();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
